// File: rtl/usb_cdc_pkg.sv
// Shared constants and the width helper for the USB CDC byte path.
package usb_cdc_pkg;

  localparam int USB_BYTE_W     = 8;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int FIFO_WMARK_DEF = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/usb_byte_ram.sv
// DEPTH x byte storage: one synchronous write port and one asynchronous read port.
// Deliberately unreset so it maps onto plain register-file or LUT RAM.
module usb_byte_ram
  import usb_cdc_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int AW    = clog2(FIFO_DEPTH_DEF)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [USB_BYTE_W-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [USB_BYTE_W-1:0] rdata_o
);

  logic [USB_BYTE_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/usb_byte_fifo.sv
// First-word-fall-through byte FIFO with valid/ready on both sides.
// Define USB_BYTE_FIFO_WMARK_EN to enable the watermark pulse; otherwise wmark_irq_o is 0.
module usb_byte_fifo
  import usb_cdc_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WMARK = FIFO_WMARK_DEF
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    flush_i,
  input  logic [USB_BYTE_W-1:0]   in_data_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [USB_BYTE_W-1:0]   out_data_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [clog2(DEPTH):0]   count_o,
  output logic                    wmark_irq_o
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_bad_depth
    $error("usb_byte_fifo: DEPTH must be a power of two >= 2");
  end
  if ((WMARK < 1) || (WMARK > DEPTH)) begin : g_bad_wmark
    $error("usb_byte_fifo: WMARK must be within 1..DEPTH");
  end

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;

  // No full-passthrough and no empty-bypass: both flags come from registered count only.
  assign in_ready_o  = (r_count != CW'(DEPTH));
  assign out_valid_o = (r_count != '0);
  assign count_o     = r_count;

  assign w_push = in_valid_i & in_ready_o;
  assign w_pop  = out_valid_o & out_ready_i;

  always_comb begin
    w_count_nxt = r_count;
    if (flush_i)              w_count_nxt = '0;
    else if (w_push && !w_pop) w_count_nxt = r_count + CW'(1);
    else if (w_pop && !w_push) w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  usb_byte_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (w_push & ~flush_i),
    .waddr_i (r_wr_ptr),
    .wdata_i (in_data_i),
    .raddr_i (r_rd_ptr),
    .rdata_o (out_data_o)
  );

`ifdef USB_BYTE_FIFO_WMARK_EN
  // Count moves by at most one per edge, so an upward crossing implies it was below
  // the mark beforehand; a flush to 0 therefore re-arms without extra state.
  logic r_wmark_irq;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_wmark_irq <= 1'b0;
    else         r_wmark_irq <= (r_count < CW'(WMARK)) && (w_count_nxt >= CW'(WMARK));
  end

  assign wmark_irq_o = r_wmark_irq;
`else
  assign wmark_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_usb_byte_fifo.sv
// Scoreboard bench for usb_byte_fifo: directed phases plus random traffic against a queue model.
module tb_usb_byte_fifo;

  localparam int DEPTH = 16;
  localparam int WMARK = 8;
`ifdef USB_BYTE_FIFO_WMARK_EN
  localparam bit WM_EN = 1'b1;
`else
  localparam bit WM_EN = 1'b0;
`endif

  logic       clk;
  logic       rstn;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
  logic       wmark_irq;

  int total = 0;
  int bad   = 0;
  int irq_pulses = 0;

  logic [7:0] mq[$];
  bit         exp_irq = 1'b0;

  usb_byte_fifo #(.DEPTH(DEPTH), .WMARK(WMARK)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .flush_i     (flush),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .count_o     (count),
    .wmark_irq_o (wmark_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: checks outputs against the model, then applies this cycle's handshakes.
  always @(negedge clk) begin
    int prev;
    bit do_pop, do_push;
    if (!rstn) begin
      check("rst_valid", int'(out_valid), 0);
      check("rst_ready", int'(in_ready), 1);
      check("rst_count", int'(count), 0);
      check("rst_irq", int'(wmark_irq), 0);
      mq.delete();
      exp_irq = 1'b0;
    end else begin
      check("count", int'(count), mq.size());
      check("in_ready", int'(in_ready), int'(mq.size() != DEPTH));
      check("out_valid", int'(out_valid), int'(mq.size() != 0));
      if (mq.size() != 0) check("out_data", int'(out_data), int'(mq[0]));
      check("wmark_irq", int'(wmark_irq), int'(exp_irq));
      if (wmark_irq) irq_pulses++;
      prev = mq.size();
      if (flush) begin
        mq.delete();
      end else begin
        do_pop  = (mq.size() != 0) && out_ready;
        do_push = in_valid && (mq.size() != DEPTH);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(in_data);
      end
      exp_irq = WM_EN && !flush && (prev < WMARK) && (mq.size() >= WMARK);
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) cyc(1'b1, base + 8'(i), 1'b0, 1'b0);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int p0;
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // single byte
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    pop_n(1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // fill, refused 17th push, wrap
    push_n(16, 8'h00);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    check("full_count", int'(count), 16);
    pop_n(4);
    push_n(4, 8'h10);
    pop_n(16);
    check("drained", int'(count), 0);

    // simultaneous push/pop at 5, then at full
    push_n(5, 8'h40);
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'h77, 1'b1, 1'b0);
    check("pp_count", int'(count), 5);
    push_n(11, 8'h60);
    cyc(1'b1, 8'hDD, 1'b1, 1'b0);
    check("full_pp_count", int'(count), 15);
    pop_n(15);

    // flush with concurrent push and pop
    push_n(7, 8'h20);
    cyc(1'b1, 8'h99, 1'b1, 1'b1);
    check("flush_count", int'(count), 0);
    check("flush_valid", int'(out_valid), 0);
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    check("post_flush_data", int'(out_data), 8'h3C);
    pop_n(1);

    // watermark crossings
    p0 = irq_pulses;
    push_n(8, 8'h80);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    pop_n(1);
    push_n(1, 8'hF0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("wmark_pulses", irq_pulses - p0, WM_EN ? 2 : 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 59) == 0));

    // async reset at count 10
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    push_n(10, 8'hB0);
    in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check("async_valid", int'(out_valid), 0);
    check("async_count", int'(count), 0);
    check("async_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    check("rst_hold_count", int'(count), 0);
    rstn = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    pop_n(1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_byte_fifo.md
# usb_byte_fifo

Synchronous byte FIFO with valid/ready handshakes on both sides. One instance sits between the MCU FIFO interface's IN output and the USB_CDC IN port. A second instance sits between the USB_CDC OUT port and the MCU FIFO interface's OUT input. Both instances decouple MCU bus timing from USB packet bursts. Optional watermark IRQ lets firmware service bursts in batches rather than per byte.

## Interface
- DEPTH, 16, number of byte entries; power of two, ≥ 2
- WMARK, 8, watermark level for the IRQ; 1 ≤ WMARK ≤ DEPTH
- clk_i  input  1  clock; all state changes on the rising edge
- rstn_i  input  1  asynchronous, active-low reset
- flush_i  input  1  synchronous clear of all stored data
- in_data_i  input  8  write data
- in_valid_i  input  1  write request; data valid while high
- in_ready_o  output  1  FIFO can accept a byte
- out_data_o  output  8  head-of-FIFO byte
- out_valid_o  output  1  head byte present
- out_ready_i  input  1  consumer takes head byte when high together with out_valid_o
- count_o  output  clog2(DEPTH)+1  current number of stored bytes
- wmark_irq_o  output  1  one-cycle pulse on watermark crossing (see Configuration)

## Operation
- Push: in_valid_i & in_ready_o at a rising edge. Writes in_data_i at wr_ptr, then increments wr_ptr.
- Pop: out_valid_o & out_ready_i at a rising edge. Increments rd_ptr.
- Pointers are clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- count_o tracks fill level:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- in_ready_o = (count_o != DEPTH), combinational from registered count.
- When full, in_ready_o is low even if a pop occurs in the same cycle. There is no full-passthrough.
- out_valid_o = (count_o != 0).
- out_data_o = mem[rd_ptr], first-word-fall-through.
- When empty, out_valid_o is low, so a same-cycle push is not visible at the output. There is no empty-bypass.
- Hold rule: while out_valid_o is high and no pop occurs, out_data_o and out_valid_o do not change. The only exception is flush_i.
- Flush: flush_i high at an edge sets wr_ptr, rd_ptr and count to 0.
  - Flush takes priority over push and pop in the same cycle; both are discarded.
  - Memory contents are not cleared.
- Reset: wr_ptr, rd_ptr and count go to 0, and any wmark state is cleared.
  - Memory is not reset. out_data_o is don't-care while out_valid_o is 0.
- Reset values of outputs:
  - in_ready_o = 1
  - out_valid_o = 0
  - count_o = 0
  - wmark_irq_o = 0
- Asserting rstn_i mid-transfer drops all stored bytes immediately. No handshake completes in a cycle where reset is low.

## Timing
- Push-to-output latency is 1 cycle. A byte pushed at edge N is on out_data_o/out_valid_o after edge N, so it can be popped at edge N+1.
- Full-to-ready latency is 1 cycle. A pop at edge N raises in_ready_o after edge N.
- Sustained throughput is 1 byte per cycle when 0 < count < DEPTH.
- count_o updates on the same edge as the handshake.
- wmark_irq_o is registered. It goes high for exactly one cycle after the edge where the count transition occurred.

## Configuration
- Macro: USB_BYTE_FIFO_WMARK_EN.
- Defined:
  - wmark_irq_o pulses one cycle when count goes from < WMARK to ≥ WMARK.
  - No re-pulse until count has dropped below WMARK again.
  - A flush to 0 re-arms the IRQ.
  - A single transition from WMARK-1 to WMARK by push gives exactly one pulse.
- Undefined: the wmark logic is absent and wmark_irq_o is tied to 0. The port list is identical in both builds.

## Structure
- Package usb_cdc_pkg holds:
  - USB_BYTE_W = 8
  - default DEPTH and WMARK constants
  - the clog2 helper function used for pointer and count widths
- Sub-module usb_byte_ram: DEPTH×8 storage.
  - One synchronous write port.
  - One asynchronous read port addressed by rd_ptr.
  - No reset.
- Pointer, count, handshake and wmark logic stay in usb_byte_fifo.

## Test plan
- Reset then single byte:
  - After reset: in_ready_o=1, out_valid_o=0, count_o=0.
  - Push 0xA5 → next cycle out_valid_o=1, out_data_o=0xA5, count_o=1.
  - Pop → out_valid_o=0.
- Fill and wrap (DEPTH=16):
  - Push 0x00..0x0F → count_o=16, in_ready_o=0. A 17th push with in_valid_i held is not accepted.
  - Pop 4 bytes, push 0x10..0x13 → pops return 0x00..0x0F, then 0x10..0x13, in order across the pointer wrap.
- Simultaneous push/pop:
  - At count=5, push 0x77 and pop together for 10 cycles → count_o stays 5 and data order is preserved.
  - At count=16 with out_ready_i=1 and in_valid_i=1 → push not accepted that cycle, count_o becomes 15.
- Flush:
  - At count=7, assert flush_i together with a push and a pop → count_o=0, out_valid_o=0 next cycle.
  - Subsequent push 0x3C reads back 0x3C.
- Watermark, with USB_BYTE_FIFO_WMARK_EN and WMARK=8:
  - Push to 8 → exactly one wmark_irq_o pulse.
  - Oscillate between 8 and 9 → no further pulse.
  - Drain to 7, push to 8 → second pulse.
  - Without the macro → wmark_irq_o constant 0.
- Reset mid-operation:
  - At count=10, pull rstn_i low asynchronously between edges → out_valid_o=0, count_o=0, in_ready_o=1 immediately, with no partial handshake.
